// File: rtl/hm_counter.sv
// BCD minutes/hours timekeeper driven by a toggle-per-minute line.
// Optional 12-hour display: define H12_MODE_EN.
module hm_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       min_tgl_i,
  input  logic       set_min_i,
  input  logic       set_hour_i,
  output logic [2:0] min_tens_o,
  output logic [3:0] min_units_o,
  output logic [1:0] hour_tens_o,
  output logic [3:0] hour_units_o,
  output logic       pm_o,
  output logic       day_tick_o
);

  // bit 0: minute toggle, bit 1: set minute, bit 2: set hour
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0] r_hist;
  logic [2:0] w_sy;

  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic       r_pend;
  logic       r_roll;

  logic       w_tick_ev;
  logic       w_setm_ev;
  logic       w_seth_ev;
  logic       w_set_any;
  logic       w_do_tick;
  logic [5:0] w_min1;
  logic [4:0] w_hour1;
  logic [5:0] w_min_n;
  logic [4:0] w_hour_n;
  logic       w_roll;
  logic [4:0] w_dhour;

  assign w_sy = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0],
                 {set_hour_i, set_min_i, min_tgl_i}};
      r_hist <= w_sy;
    end
  end

  assign w_tick_ev = w_sy[0] ^ r_hist[0];
  assign w_setm_ev = w_sy[1] & ~r_hist[1];
  assign w_seth_ev = w_sy[2] & ~r_hist[2];
  assign w_set_any = w_setm_ev | w_seth_ev;
  // a tick colliding with a set is deferred one cycle
  assign w_do_tick = r_pend | (w_tick_ev & ~w_set_any);

  always_comb begin
    w_min1  = r_min;
    w_hour1 = r_hour;
    w_roll  = 1'b0;
    if (w_do_tick) begin
      if (r_min == 6'd59) begin
        w_min1 = 6'd0;
        if (r_hour == 5'd23) begin
          w_hour1 = 5'd0;
          w_roll  = 1'b1;
        end else begin
          w_hour1 = r_hour + 5'd1;
        end
      end else begin
        w_min1 = r_min + 6'd1;
      end
    end
    w_min_n  = w_min1;
    w_hour_n = w_hour1;
    if (w_setm_ev)
      w_min_n = (w_min1 == 6'd59) ? 6'd0 : w_min1 + 6'd1;
    if (w_seth_ev)
      w_hour_n = (w_hour1 == 5'd23) ? 5'd0 : w_hour1 + 5'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_min  <= '0;
      r_hour <= '0;
      r_pend <= 1'b0;
      r_roll <= 1'b0;
    end else begin
      r_min  <= w_min_n;
      r_hour <= w_hour_n;
      r_pend <= w_tick_ev & w_set_any;
      r_roll <= w_roll;
    end
  end

`ifdef H12_MODE_EN
  localparam logic [1:0] RST_HT = 2'd1;
  localparam logic [3:0] RST_HU = 4'd2;

  always_comb begin
    w_dhour = r_hour;
    if (r_hour == 5'd0)
      w_dhour = 5'd12;
    else if (r_hour > 5'd12)
      w_dhour = r_hour - 5'd12;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) pm_o <= 1'b0;
    else         pm_o <= (r_hour >= 5'd12);
  end
`else
  localparam logic [1:0] RST_HT = 2'd0;
  localparam logic [3:0] RST_HU = 4'd0;

  assign w_dhour = r_hour;
  assign pm_o    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      min_tens_o   <= '0;
      min_units_o  <= '0;
      hour_tens_o  <= RST_HT;
      hour_units_o <= RST_HU;
      day_tick_o   <= 1'b0;
    end else begin
      min_tens_o   <= 3'(r_min / 6'd10);
      min_units_o  <= 4'(r_min % 6'd10);
      hour_tens_o  <= 2'(w_dhour / 5'd10);
      hour_units_o <= 4'(w_dhour % 5'd10);
      day_tick_o   <= r_roll;
    end
  end

endmodule

// File: tb/tb_hm_counter.sv
// Self-checking bench for hm_counter: vector table, corner sequences,
// and random events against a minutes-of-day reference model.
module tb_hm_counter;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic       min_tgl_i = 1'b0;
  logic       set_min_i = 1'b0;
  logic       set_hour_i = 1'b0;
  logic [2:0] min_tens_o;
  logic [3:0] min_units_o;
  logic [1:0] hour_tens_o;
  logic [3:0] hour_units_o;
  logic       pm_o;
  logic       day_tick_o;

  int nvec = 0;
  int nerr = 0;
  int dt_cnt = 0;

  hm_counter #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .min_tgl_i   (min_tgl_i),
    .set_min_i   (set_min_i),
    .set_hour_i  (set_hour_i),
    .min_tens_o  (min_tens_o),
    .min_units_o (min_units_o),
    .hour_tens_o (hour_tens_o),
    .hour_units_o(hour_units_o),
    .pm_o        (pm_o),
    .day_tick_o  (day_tick_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rstn_i && day_tick_o) dt_cnt++;

  typedef struct {
    int nh;
    int nm;
    int nt;
    int eh;
    int em;
  } vec_t;

  // {ht, hu, mt, mu, pm} expected on the display for internal h:m
  function automatic logic [13:0] disp(int h, int m);
    int  dh;
    bit  pm;
    dh = h;
    pm = 1'b0;
`ifdef H12_MODE_EN
    pm = (h >= 12);
    dh = h % 12;
    if (dh == 0) dh = 12;
`endif
    return {2'(dh / 10), 4'(dh % 10), 3'(m / 10), 4'(m % 10), pm};
  endfunction

  task automatic check(string name, int h, int m);
    logic [13:0] act;
    logic [13:0] exp;
    act = {hour_tens_o, hour_units_o, min_tens_o, min_units_o, pm_o};
    exp = disp(h, m);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d%0d:%0d%0d pm=%0b want %0d%0d:%0d%0d pm=%0b",
               name, act[13:12], act[11:8], act[7:5], act[4:1], act[0],
               exp[13:12], exp[11:8], exp[7:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    min_tgl_i = 1'b0;
    set_min_i = 1'b0;
    set_hour_i = 1'b0;
    cyc(2);
    rstn_i = 1'b1;
    cyc(2);
  endtask

  task automatic ev(bit t, bit sm, bit sh);
    if (t) min_tgl_i = ~min_tgl_i;
    set_min_i = sm;
    set_hour_i = sh;
    cyc(3);
    set_min_i = 1'b0;
    set_hour_i = 1'b0;
    cyc(3 + int'($urandom_range(0, 4)));
  endtask

  task automatic apply(int nh, int nm, int nt);
    repeat (nh) ev(1'b0, 1'b0, 1'b1);
    repeat (nm) ev(1'b0, 1'b1, 1'b0);
    repeat (nt) ev(1'b1, 1'b0, 1'b0);
  endtask

  vec_t vt[13];
  int   d0;
  int   mh, mm, expdt;
  int   op;
  bit   rt, rsm, rsh;

  initial begin
    vt[0]  = '{0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 0, 1};
    vt[2]  = '{0, 5, 0, 0, 6};
    vt[3]  = '{3, 0, 0, 3, 6};
    vt[4]  = '{0, 54, 0, 3, 0};
    vt[5]  = '{21, 0, 0, 0, 0};
    vt[6]  = '{0, 59, 1, 1, 0};
    vt[7]  = '{22, 0, 0, 23, 0};
    vt[8]  = '{0, 59, 1, 0, 0};
    vt[9]  = '{12, 0, 0, 12, 0};
    vt[10] = '{1, 5, 0, 13, 5};
    vt[11] = '{11, 0, 0, 0, 5};
    vt[12] = '{0, 0, 2, 0, 7};

    rstn_i = 1'b0;
    cyc(1);
    #1;
    check("reset_state", 0, 0);
    check_int("reset_daytick", int'(day_tick_o), 0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      apply(vt[i].nh, vt[i].nm, vt[i].nt);
      check($sformatf("vec%0d", i), vt[i].eh, vt[i].em);
    end

    // latency and 60 slow minute toggles
    do_reset();
    min_tgl_i = 1'b1;
    cyc(3);
    check("lat_before", 0, 0);
    cyc(1);
    check("lat_at", 0, 1);
    cyc(56);
    for (int i = 1; i < 60; i++) begin
      min_tgl_i = ~min_tgl_i;
      cyc(60);
    end
    check("sixty_ticks", 1, 0);

    // midnight rollover
    do_reset();
    apply(23, 59, 0);
    check("preset_2359", 23, 59);
    d0 = dt_cnt;
    min_tgl_i = ~min_tgl_i;
    cyc(3);
    check("mid_before", 23, 59);
    check_int("mid_dt_before", int'(day_tick_o), 0);
    cyc(1);
    check("mid_at", 0, 0);
    check_int("mid_dt_at", int'(day_tick_o), 1);
    cyc(1);
    check_int("mid_dt_after", int'(day_tick_o), 0);
    cyc(2);
    check_int("mid_dt_count", dt_cnt - d0, 1);

    // set wrap, no carry and no day tick
    do_reset();
    apply(10, 59, 0);
    ev(1'b0, 1'b1, 1'b0);
    check("setm_wrap", 10, 0);
    do_reset();
    apply(23, 10, 0);
    d0 = dt_cnt;
    ev(1'b0, 1'b0, 1'b1);
    check("seth_wrap", 0, 10);
    check_int("seth_wrap_dt", dt_cnt - d0, 0);

    // tick colliding with set_hour
    do_reset();
    apply(5, 59, 0);
    min_tgl_i = ~min_tgl_i;
    set_hour_i = 1'b1;
    cyc(3);
    check("coll_before", 5, 59);
    cyc(1);
    check("coll_set", 6, 59);
    cyc(1);
    check("coll_tick", 7, 0);
    set_hour_i = 1'b0;
    cyc(4);

    // async reset with a tick pending
    do_reset();
    apply(14, 37, 0);
    check("preset_1437", 14, 37);
    d0 = dt_cnt;
    min_tgl_i = ~min_tgl_i;
    set_min_i = 1'b1;
    cyc(3);
    rstn_i = 1'b0;
    #1;
    check("rst_async", 0, 0);
    check_int("rst_async_dt", int'(day_tick_o), 0);
    check_int("rst_async_pm", int'(pm_o), 0);
    min_tgl_i = 1'b0;
    set_min_i = 1'b0;
    cyc(2);
    rstn_i = 1'b1;
    cyc(10);
    check("rst_release", 0, 0);
    check_int("rst_release_dt", dt_cnt - d0, 0);

    // random events against the minutes-of-day model
    do_reset();
    mh = 0;
    mm = 0;
    expdt = 0;
    d0 = dt_cnt;
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 9));
      rt  = (op < 5) || (op == 9);
      rsm = (op == 5) || (op == 7) || (op == 9);
      rsh = (op == 6) || (op == 7) || (op == 8);
      if (op == 8) rt = 1'b1;
      ev(rt, rsm, rsh);
      if (rsm) mm = (mm + 1) % 60;
      if (rsh) mh = (mh + 1) % 24;
      if (rt) begin
        if (mh * 60 + mm == 1439) expdt++;
        mm = mh * 60 + mm + 1;
        mh = (mm / 60) % 24;
        mm = mm % 60;
      end
      check($sformatf("rand%0d", i), mh, mm);
    end
    check_int("rand_daytick", dt_cnt - d0, expdt);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
